sfx_tone_player: RTL and testbench

Sound-effect sample generator for the shooter game; sits directly upstream of the audio controller and feeds its DAC FIFO. On a single-cycle game event trigger it synthesises a decaying square-wave tone or noise burst, one 10-bit signed sample at a time. It writes each sample to both channels under the controller's `audio_out_allowed` / `write_audio_out` flow control. Sample rate is set by codec FIFO drain (48 kHz); this block only keeps the FIFO fed while an effect is active.

---
 rtl/sfx_tone_player.sv | 161 ++++++++++++++++
 tb/tb_sfx_tone_player.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_tone_player.sv
// Sound-effect sample generator: decaying square-wave tones and an LFSR noise burst,
// written one sample at a time into the audio controller under its flow control.
module sfx_tone_player #(
  parameter int unsigned SHOT_HALF_PERIOD = 24,
  parameter int unsigned HIT_HALF_PERIOD  = 60,
  parameter int unsigned SHOT_SAMPLES     = 4800,
  parameter int unsigned HIT_SAMPLES      = 9600,
  parameter int unsigned EXPLODE_SAMPLES  = 24000,
  parameter int unsigned START_AMP        = 255,
  parameter int unsigned HOLDOFF          = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       trigger_shot,
  input  logic       trigger_hit,
  input  logic       trigger_explode,
  input  logic       audio_out_allowed,
  output logic [9:0] left_channel_audio_out,
  output logic [9:0] right_channel_audio_out,
  output logic       write_audio_out,
  output logic       busy,
  output logic [1:0] active_effect
);

  localparam int unsigned CntW  = 15;
  localparam int unsigned PhW   = 7;
  localparam int unsigned HoldW = $clog2(HOLDOFF + 2);

  localparam logic [CntW-1:0]  ShotLast    = CntW'(SHOT_SAMPLES - 1);
  localparam logic [CntW-1:0]  HitLast     = CntW'(HIT_SAMPLES - 1);
  localparam logic [CntW-1:0]  ExplodeLast = CntW'(EXPLODE_SAMPLES - 1);
  localparam logic [PhW-1:0]   ShotHalfM1  = PhW'(SHOT_HALF_PERIOD - 1);
  localparam logic [PhW-1:0]   HitHalfM1   = PhW'(HIT_HALF_PERIOD - 1);
  localparam logic [8:0]       StartAmp    = 9'(START_AMP);
  localparam logic [HoldW-1:0] HoldLoad    = HoldW'(HOLDOFF);

  typedef enum logic [1:0] {StIdle, StWaitSpace, StHold} state_e;

  state_e           state_q;
  logic [1:0]       effect_q;
  logic             busy_q;
  logic             write_q;
  logic [9:0]       sample_q;
  logic [8:0]       amp_q;
  logic [CntW-1:0]  count_q;
  logic [PhW-1:0]   phase_q;
  logic             pol_q;
  logic [15:0]      lfsr_q;
  logic [HoldW-1:0] hold_q;
  logic             done_q;

  logic [1:0]      trig_code;
  logic            accept;
  logic [CntW-1:0] last_idx;
  logic [PhW-1:0]  half_m1;
  logic            bit_pos;
  logic [9:0]      sample_d;
  logic [8:0]      amp_sub;
  logic [8:0]      amp_d;
  logic            last_write;
  logic [15:0]     lfsr_d;

  always_comb begin
    trig_code = 2'd0;
    if (trigger_explode)  trig_code = 2'd3;
    else if (trigger_hit) trig_code = 2'd2;
    else if (trigger_shot) trig_code = 2'd1;
    // Equal priority restarts; effect_q is 0 while idle so any trigger is accepted.
    accept = (trig_code != 2'd0) && (trig_code >= effect_q);

    case (effect_q)
      2'd1:    last_idx = ShotLast;
      2'd2:    last_idx = HitLast;
      default: last_idx = ExplodeLast;
    endcase
    half_m1 = (effect_q == 2'd2) ? HitHalfM1 : ShotHalfM1;

    bit_pos  = (effect_q == 2'd3) ? lfsr_q[0] : pol_q;
    sample_d = bit_pos ? {1'b0, amp_q} : -{1'b0, amp_q};

    amp_sub = amp_q - (amp_q >> 4);
    amp_d   = amp_q;
    if (count_q[7:0] == 8'hff) amp_d = (amp_sub == 9'd0) ? 9'd0 : amp_sub - 9'd1;
    last_write = (count_q == last_idx) || (amp_d == 9'd0);

    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      effect_q <= 2'd0;
      busy_q   <= 1'b0;
      write_q  <= 1'b0;
      sample_q <= 10'd0;
      amp_q    <= 9'd0;
      count_q  <= '0;
      phase_q  <= '0;
      pol_q    <= 1'b1;
      lfsr_q   <= 16'hACE1;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      // Holdoff keeps running across a restart so write spacing survives it.
      if (hold_q != '0) hold_q <= hold_q - 1'b1;
      if (accept) begin
        state_q  <= StWaitSpace;
        effect_q <= trig_code;
        busy_q   <= 1'b1;
        amp_q    <= StartAmp;
        count_q  <= '0;
        phase_q  <= '0;
        pol_q    <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StWaitSpace: begin
            if (audio_out_allowed && (hold_q == '0)) begin
              sample_q <= sample_d;
              write_q  <= 1'b1;
              lfsr_q   <= lfsr_d;
              amp_q    <= amp_d;
              count_q  <= count_q + 1'b1;
              if (phase_q == half_m1) begin
                phase_q <= '0;
                pol_q   <= ~pol_q;
              end else begin
                phase_q <= phase_q + 1'b1;
              end
              hold_q  <= HoldLoad;
              done_q  <= last_write;
              state_q <= StHold;
            end
          end
          StHold: begin
            if (hold_q == '0) begin
              if (done_q) begin
                state_q  <= StIdle;
                effect_q <= 2'd0;
                busy_q   <= 1'b0;
                sample_q <= 10'd0;
              end else begin
                state_q <= StWaitSpace;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign write_audio_out         = write_q;
  assign busy                    = busy_q;
  assign active_effect           = effect_q;

endmodule

// File: tb/tb_sfx_tone_player.sv
// Directed bench for sfx_tone_player: a negedge monitor scores every write strobe
// against a small tone/noise reference model; the main thread runs the scenarios.
module tb_sfx_tone_player;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       trigger_shot = 1'b0;
  logic       trigger_hit = 1'b0;
  logic       trigger_explode = 1'b0;
  logic       audio_out_allowed = 1'b0;
  logic [9:0] left_channel_audio_out;
  logic [9:0] right_channel_audio_out;
  logic       write_audio_out;
  logic       busy;
  logic [1:0] active_effect;

  always #10 CLOCK_50 = ~CLOCK_50;

  sfx_tone_player dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .trigger_shot           (trigger_shot),
    .trigger_hit            (trigger_hit),
    .trigger_explode        (trigger_explode),
    .audio_out_allowed      (audio_out_allowed),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out        (write_audio_out),
    .busy                   (busy),
    .active_effect          (active_effect)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model state
  int          m_eff = 0;
  int          m_n, m_amp, m_len, m_half;
  bit          m_done = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;

  // Monitor state
  int cyc = 0, last_cyc = 0, min_gap = 1000000;
  bit have_last = 1'b0, prev_wr = 1'b0;
  int n_strobes = 0, sample_bad = 0, spacing_bad = 0;
  int cap[0:299];

  task automatic model_load(input int eff);
    m_eff     = eff;
    m_n       = 0;
    m_amp     = 255;
    m_done    = 1'b0;
    n_strobes = 0;
    m_len     = (eff == 1) ? 4800 : (eff == 2) ? 9600 : 24000;
    m_half    = (eff == 2) ? 60 : 24;
  endtask

  always @(negedge CLOCK_50) begin
    logic [9:0] exp_v;
    bit         pos;
    cyc++;
    if (write_audio_out) begin
      if (prev_wr) spacing_bad++;
      if (have_last) begin
        if (cyc - last_cyc - 1 < 3) spacing_bad++;
        if (cyc - last_cyc - 1 < min_gap) min_gap = cyc - last_cyc - 1;
      end
      have_last = 1'b1;
      last_cyc  = cyc;
      n_strobes++;
      if (left_channel_audio_out != right_channel_audio_out) sample_bad++;
      if (m_eff == 0 || m_done) begin
        sample_bad++;
      end else begin
        pos   = (m_eff == 3) ? m_lfsr[0] : (((m_n / m_half) % 2) == 0);
        exp_v = pos ? 10'(m_amp) : 10'(1024 - m_amp);
        if (left_channel_audio_out != exp_v) begin
          if (sample_bad < 5)
            $display("FAIL sample %0d of effect %0d: got %0d expected %0d",
                     m_n, m_eff, left_channel_audio_out, exp_v);
          sample_bad++;
        end
        if (m_n < 300) cap[m_n] = int'(left_channel_audio_out);
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        if (m_n % 256 == 255) m_amp = (m_amp - m_amp / 16 - 1 < 0) ? 0 : m_amp - m_amp / 16 - 1;
        m_n++;
        if (m_n == m_len || m_amp == 0) m_done = 1'b1;
      end
    end
    prev_wr = write_audio_out;
  end

  // One-cycle trigger pulse; returns just after the negedge following the sampling edge.
  task automatic pulse(input bit s, input bit h, input bit e, input int load_eff);
    @(negedge CLOCK_50);
    #1;
    trigger_shot    = s;
    trigger_hit     = h;
    trigger_explode = e;
    if (load_eff != 0) model_load(load_eff);
    @(negedge CLOCK_50);
    #1;
    trigger_shot    = 1'b0;
    trigger_hit     = 1'b0;
    trigger_explode = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, int'(busy), 0);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int k = 0;
    while (n_strobes < target && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(tag, int'(n_strobes >= target), 1);
  endtask

  initial begin
    int s0;
    // Reset held three edges with every trigger asserted
    trigger_shot = 1'b1;
    trigger_hit = 1'b1;
    trigger_explode = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_write", int'(write_audio_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active", int'(active_effect), 0);
    check("rst_left", int'(left_channel_audio_out), 0);
    check("rst_right", int'(right_channel_audio_out), 0);
    #1;
    reset = 1'b0;
    trigger_shot = 1'b0;
    trigger_hit = 1'b0;
    trigger_explode = 1'b0;
    audio_out_allowed = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("no_strobe_after_reset", n_strobes, 0);

    // Noise burst from the reset seed; 16'hACE1 has bit0 = 1 so the first sample is +255
    sample_bad = 0;
    pulse(1'b0, 1'b0, 1'b1, 3);
    check("explode_active", int'(active_effect), 3);
    check("explode_busy", int'(busy), 1);
    check("explode_lat_low", int'(write_audio_out), 0);
    @(negedge CLOCK_50);
    check("explode_first_strobe", int'(write_audio_out), 1);
    check("explode_first_value", int'(left_channel_audio_out), 255);
    wait_idle("explode_idle", 70000);
    check("explode_model_done", int'(m_done), 1);
    check("explode_len", n_strobes, m_n);
    check("explode_samples", sample_bad, 0);
    check("explode_idle_active", int'(active_effect), 0);
    check("explode_idle_left", int'(left_channel_audio_out), 0);

    // Shot tone with a 100-cycle backpressure window in the middle
    sample_bad = 0;
    min_gap = 1000000;
    pulse(1'b1, 1'b0, 1'b0, 1);
    check("shot_active", int'(active_effect), 1);
    @(negedge CLOCK_50);
    check("shot_first_strobe", int'(write_audio_out), 1);
    wait_strobes("shot_reach_1000", 1000, 10000);
    #1;
    audio_out_allowed = 1'b0;
    s0 = n_strobes;
    repeat (100) @(negedge CLOCK_50);
    check("bp_no_strobe", n_strobes - s0, 0);
    check("bp_busy", int'(busy), 1);
    #1;
    audio_out_allowed = 1'b1;
    wait_idle("shot_idle", 40000);
    check("shot_s0", cap[0], 255);
    check("shot_s23", cap[23], 255);
    check("shot_s24", cap[24], 10'h301);
    check("shot_s47", cap[47], 10'h301);
    check("shot_s48", cap[48], 255);
    check("shot_s255", cap[255], 255);
    check("shot_s256_decayed", cap[256], 239);
    check("shot_count", n_strobes, 4800);
    check("shot_samples", sample_bad, 0);
    check("shot_min_gap", int'(min_gap >= 4), 1);

    // Priority: hit beats shot, later shot ignored, explode restarts
    sample_bad = 0;
    pulse(1'b1, 1'b1, 1'b0, 2);
    check("prio_hit_wins", int'(active_effect), 2);
    wait_strobes("prio_hit_strobes", 10, 1000);
    pulse(1'b1, 1'b0, 1'b0, 0);
    check("prio_shot_ignored", int'(active_effect), 2);
    wait_strobes("prio_hit_continues", 20, 1000);
    pulse(1'b0, 1'b0, 1'b1, 3);
    check("prio_explode_active", int'(active_effect), 3);
    wait_strobes("prio_explode_strobe", 1, 100);
    check("prio_explode_amp",
          int'(left_channel_audio_out == 10'd255 || left_channel_audio_out == 10'h301), 1);
    wait_strobes("prio_explode_more", 5, 1000);
    check("prio_samples", sample_bad, 0);

    // Reset mid-effect kills the strobe on the next cycle
    @(negedge CLOCK_50);
    #1;
    reset = 1'b1;
    m_eff = 0;
    @(negedge CLOCK_50);
    check("midrst_write", int'(write_audio_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_active", int'(active_effect), 0);
    #1;
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    repeat (10) @(negedge CLOCK_50);
    check("spacing", spacing_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
